// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter that shares one single-port data RAM between the CPU load/store
// path and a debug/loader port, with address checking, per-port counters and a CPU stall.
module data_memory_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0100,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic                  cpu_stall,

  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [31:0]           dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_ack,
  output logic                  dbg_err,

  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic [15:0]           cpu_count,
  output logic [15:0]           dbg_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_CPU = 2'd1,
    ACC_DBG = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } grant_e;

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] cpu_hold_q, dbg_hold_q;
  logic [15:0]           cpu_cnt_q, dbg_cnt_q;

  logic in_cpu, in_dbg;
  logic cpu_bad, dbg_bad;
  logic cpu_ok, dbg_ok;

  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= ADDR_LIMIT);
  endfunction

  assign in_cpu  = (state_q == ACC_CPU);
  assign in_dbg  = (state_q == ACC_DBG);
  assign cpu_bad = addr_bad(cpu_addr);
  assign dbg_bad = addr_bad(dbg_addr);
  assign cpu_ok  = in_cpu & ~cpu_bad;
  assign dbg_ok  = in_dbg & ~dbg_bad;

  // Every access state falls back to IDLE, which guarantees the idle cycle between grants.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = IDLE;
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (cpu_req && (!dbg_req || last_grant_q == GNT_DBG)) begin
        state_d      = ACC_CPU;
        last_grant_d = GNT_CPU;
      end else if (dbg_req) begin
        state_d      = ACC_DBG;
        last_grant_d = GNT_DBG;
      end
    end
  end

  // NOTE: state uses non-blocking assignments only; blocking here would race with readers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the read-hold registers are plain flops, not RAM, so they are reset with the rest.
      state_q      <= IDLE;
      last_grant_q <= GNT_DBG;
      cpu_hold_q   <= '0;
      dbg_hold_q   <= '0;
      cpu_cnt_q    <= '0;
      dbg_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (cpu_ok) begin
        if (!cpu_we) cpu_hold_q <= mem_rdata;
        if (cpu_cnt_q != 16'hFFFF) cpu_cnt_q <= cpu_cnt_q + 16'd1;
      end
      if (dbg_ok) begin
        if (!dbg_we) dbg_hold_q <= mem_rdata;
        if (dbg_cnt_q != 16'hFFFF) dbg_cnt_q <= dbg_cnt_q + 16'd1;
      end
    end
  end

  // RAM side: a rejected address still drives mem_addr but never enables the RAM.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (state_q)
      ACC_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we & ~cpu_bad;
        mem_re    = ~cpu_we & ~cpu_bad;
      end
      ACC_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_we    = dbg_we & ~dbg_bad;
        mem_re    = ~dbg_we & ~dbg_bad;
      end
      default: ;
    endcase
  end

  assign cpu_ack   = in_cpu;
  assign cpu_err   = in_cpu & cpu_bad;
  assign cpu_rdata = in_cpu ? (cpu_bad ? '0 : mem_rdata) : cpu_hold_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

  assign dbg_ack   = in_dbg;
  assign dbg_err   = in_dbg & dbg_bad;
  assign dbg_rdata = in_dbg ? (dbg_bad ? '0 : mem_rdata) : dbg_hold_q;

  assign cpu_count = cpu_cnt_q;
  assign dbg_count = dbg_cnt_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: a behavioural RAM, a shadow copy for expected
// read data, and a negedge monitor that pops one expectation per ack.
module tb_data_memory_arbiter;

  localparam int          DW    = 32;
  localparam logic [31:0] LIMIT = 32'h0000_0100;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack, dbg_err;
  logic [31:0]   dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re;
  logic [15:0]   cpu_count, dbg_count;

  typedef struct {
    logic        is_dbg;
    logic        we;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [31:0] tbmem [64];
  logic [31:0] shadow[64];
  logic [15:0] exp_cpu_cnt = 16'd0;
  logic [15:0] exp_dbg_cnt = 16'd0;

  data_memory_arbiter #(.ADDR_LIMIT(LIMIT), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_ack   (dbg_ack),
    .dbg_err   (dbg_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .cpu_count (cpu_count),
    .dbg_count (dbg_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: combinational read, write on the rising edge.
  always @(posedge clk) if (mem_we) tbmem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = tbmem[mem_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= LIMIT);
  endfunction

  task automatic push(input logic is_dbg, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input int at_cyc);
    exp_t e;
    e.is_dbg = is_dbg;
    e.we     = we;
    e.err    = bad_addr(a);
    e.rdata  = e.err ? 32'd0 : shadow[a[7:2]];
    e.cyc    = at_cyc;
    if (!e.err && we) shadow[a[7:2]] = d;
    exp_q.push_back(e);
  endtask

  task automatic on_ack(input logic is_dbg);
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    rd = is_dbg ? dbg_rdata : cpu_rdata;
    er = is_dbg ? dbg_err : cpu_err;
    if (exp_q.size() == 0) begin
      check(is_dbg ? "dbg_spurious_ack" : "cpu_spurious_ack", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("ack_port", 32'(is_dbg), 32'(e.is_dbg));
    check("ack_cycle", 32'(cyc), 32'(e.cyc));
    check("ack_err", 32'(er), 32'(e.err));
    if (e.err || !e.we) check("ack_rdata", rd, e.rdata);
    if (e.err) check("mem_en_on_err", 32'({mem_we, mem_re}), 32'd0);
    else       check("mem_en", 32'({mem_we, mem_re}), e.we ? 32'd2 : 32'd1);
    if (!is_dbg) check("stall_in_ack", 32'(cpu_stall), 32'd0);
    if (!e.err) begin
      if (e.is_dbg && exp_dbg_cnt != 16'hFFFF) exp_dbg_cnt = exp_dbg_cnt + 16'd1;
      if (!e.is_dbg && exp_cpu_cnt != 16'hFFFF) exp_cpu_cnt = exp_cpu_cnt + 16'd1;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (cpu_ack) on_ack(1'b0);
      if (dbg_ack) on_ack(1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each transfer leaves the request low on return; a following call re-raises it
  // in the same time step, so back-to-back calls model a continuously held request.
  task automatic cpu_xfer(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    push(1'b0, we, a, d, cyc + 1);
    #3 check("cpu_stall_arb", 32'(cpu_stall), 32'd1);
    step();
    step();
    cpu_req = 1'b0;
  endtask

  task automatic dbg_xfer(input logic we, input logic [31:0] a, input logic [31:0] d);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    push(1'b1, we, a, d, cyc + 1);
    step();
    step();
    dbg_req = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_mem_en", 32'({mem_we, mem_re}), 32'd0);
    check("rst_cpu_count", 32'(cpu_count), 32'd0);
    check("rst_dbg_count", 32'(dbg_count), 32'd0);
    exp_cpu_cnt = 16'd0;
    exp_dbg_cnt = 16'd0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    int k;
    reset   = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      tbmem[i]  = 32'hA5A5_0000 + 32'(i);
      shadow[i] = 32'hA5A5_0000 + 32'(i);
    end

    #3;
    check("por_acks", 32'({cpu_ack, dbg_ack, cpu_err, dbg_err}), 32'd0);
    check("por_mem_en", 32'({mem_we, mem_re}), 32'd0);
    check("por_mem_addr", mem_addr, 32'd0);
    check("por_cpu_rdata", cpu_rdata, 32'd0);
    check("por_dbg_rdata", dbg_rdata, 32'd0);
    check("por_counts", {cpu_count, dbg_count}, 32'd0);
    step();
    reset = 1'b1;

    // CPU write then read-back of the same word.
    cpu_xfer(1'b1, 32'h10, 32'h1234_5678);
    cpu_xfer(1'b0, 32'h10, 32'h0);
    step();
    check("t1_cpu_count", 32'(cpu_count), 32'(exp_cpu_cnt));
    check("t1_cpu_count_2", 32'(cpu_count), 32'd2);
    check("t1_cpu_rdata_hold", cpu_rdata, 32'h1234_5678);
    check("t1_idle_mem_addr", mem_addr, 32'd0);

    // Collision after reset: CPU first, then strict alternation while both hold.
    apply_reset();
    k = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14; cpu_wdata = '0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h14; dbg_wdata = 32'hCAFE_F00D;
    push(1'b0, 1'b0, 32'h14, 32'h0, k + 1);
    push(1'b1, 1'b1, 32'h14, 32'hCAFE_F00D, k + 3);
    push(1'b0, 1'b0, 32'h14, 32'h0, k + 5);
    push(1'b1, 1'b1, 32'h14, 32'hCAFE_F00D, k + 7);
    for (int i = 0; i < 8; i++) step();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    step();
    check("t2_cpu_count", 32'(cpu_count), 32'(exp_cpu_cnt));
    check("t2_dbg_count", 32'(dbg_count), 32'(exp_dbg_cnt));
    check("t2_cpu_rdata_hold", cpu_rdata, 32'hCAFE_F00D);

    // Debug reads that must be rejected: misaligned, and exactly at the limit.
    dbg_xfer(1'b0, 32'h102, 32'h0);
    dbg_xfer(1'b0, 32'h100, 32'h0);
    dbg_xfer(1'b0, 32'h0FC, 32'h0);
    step();
    check("t3_dbg_count", 32'(dbg_count), 32'(exp_dbg_cnt));
    check("t3_dbg_rdata_hold", dbg_rdata, 32'hA5A5_003F);

    // Reset in the middle of a CPU write: no commit, everything cleared at once.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD_BEEF;
    step();
    #1 check("t4_mem_we_pre", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check("t4_mem_we_rst", 32'(mem_we), 32'd0);
    check("t4_cpu_ack_rst", 32'(cpu_ack), 32'd0);
    check("t4_counts_rst", {cpu_count, dbg_count}, 32'd0);
    check("t4_rdata_rst", cpu_rdata, 32'd0);
    cpu_req = 1'b0;
    exp_cpu_cnt = 16'd0;
    exp_dbg_cnt = 16'd0;
    step();
    reset = 1'b1;
    cpu_xfer(1'b0, 32'h20, 32'h0);
    step();
    check("t4_cpu_count", 32'(cpu_count), 32'(exp_cpu_cnt));

    // Request dropped during the access cycle: one ack, no repeat.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0;
    push(1'b0, 1'b0, 32'h10, 32'h0, cyc + 1);
    step();
    cpu_req = 1'b0;
    step();
    step();
    step();
    check("t6_cpu_count", 32'(cpu_count), 32'(exp_cpu_cnt));
    check("t6_idle", 32'({cpu_ack, mem_re, mem_we}), 32'd0);

    // Saturation of the CPU counter.
    force dut.cpu_cnt_q = 16'hFFFE;
    #1;
    release dut.cpu_cnt_q;
    check("t5_cpu_count_forced", 32'(cpu_count), 32'h0000_FFFE);
    exp_cpu_cnt = 16'hFFFE;
    cpu_xfer(1'b1, 32'h30, 32'h0BAD_F00D);
    cpu_xfer(1'b0, 32'h30, 32'h0);
    cpu_xfer(1'b0, 32'h10, 32'h0);
    step();
    check("t5_cpu_count_sat", 32'(cpu_count), 32'h0000_FFFF);
    check("t5_cpu_count_model", 32'(cpu_count), 32'(exp_cpu_cnt));

    step();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
